// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift
// window, and taps are flagged valid only for complete, non-border positions.
module window3x3_linebuf #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] p00,
  output logic [DATA_W-1:0] p01,
  output logic [DATA_W-1:0] p02,
  output logic [DATA_W-1:0] p10,
  output logic [DATA_W-1:0] p11,
  output logic [DATA_W-1:0] p12,
  output logic [DATA_W-1:0] p20,
  output logic [DATA_W-1:0] p21,
  output logic [DATA_W-1:0] p22,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]     col, c_eff, col_nxt;
  logic [RW-1:0]     row, r_eff, row_nxt;
  logic              last_col, last_row;
  logic              win_ok;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  // sof overrides the counters so the qualifying pixel is always (0,0)
  always_comb begin
    c_eff    = sof ? '0 : col;
    r_eff    = sof ? '0 : row;
    last_col = (c_eff == CW'(IMG_W - 1));
    last_row = (r_eff == RW'(IMG_H - 1));
    win_ok   = (r_eff >= RW'(2)) && (c_eff >= CW'(2));
    col_nxt  = last_col ? '0 : c_eff + CW'(1);
    row_nxt  = r_eff;
    if (last_col) begin
      row_nxt = last_row ? '0 : r_eff + RW'(1);
    end
    lb1_rd = lb1[c_eff];
    lb2_rd = lb2[c_eff];
  end

  // Line-buffer RAM is deliberately unreset; asynchronous read gives
  // read-before-write at the shared column address.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[c_eff] <= pix_in;
      lb2[c_eff] <= lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      p00        <= '0;
      p01        <= '0;
      p02        <= '0;
      p10        <= '0;
      p11        <= '0;
      p12        <= '0;
      p20        <= '0;
      p21        <= '0;
      p22        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        col        <= col_nxt;
        row        <= row_nxt;
        p00        <= p01;
        p01        <= p02;
        p02        <= lb2_rd;
        p10        <= p11;
        p11        <= p12;
        p12        <= lb1_rd;
        p20        <= p21;
        p21        <= p22;
        p22        <= pix_in;
        win_valid  <= win_ok;
        frame_done <= last_row && last_col;
      end
    end
  end

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Randomised bench for window3x3_linebuf: a 4x4 instance for the directed
// frame scenarios and a 24x13 instance for a larger random image.
module tb_window3x3_linebuf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;

  logic [7:0] s00, s01, s02, s10, s11, s12, s20, s21, s22;
  logic [7:0] l00, l01, l02, l10, l11, l12, l20, l21, l22;
  logic       s_wv, s_fd, l_wv, l_fd;

  always #5 clk = ~clk;

  window3x3_linebuf #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_s (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p00(s00), .p01(s01), .p02(s02), .p10(s10), .p11(s11), .p12(s12),
    .p20(s20), .p21(s21), .p22(s22), .win_valid(s_wv), .frame_done(s_fd));

  window3x3_linebuf #(.IMG_W(24), .IMG_H(13), .DATA_W(8)) dut_l (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p00(l00), .p01(l01), .p02(l02), .p10(l10), .p11(l11), .p12(l12),
    .p20(l20), .p21(l21), .p22(l22), .win_valid(l_wv), .frame_done(l_fd));

  logic        use_large = 1'b0;
  logic [71:0] obs_taps;
  logic        obs_wv, obs_fd;

  always_comb begin
    if (use_large) begin
      obs_taps = {l00, l01, l02, l10, l11, l12, l20, l21, l22};
      obs_wv   = l_wv;
      obs_fd   = l_fd;
    end else begin
      obs_taps = {s00, s01, s02, s10, s11, s12, s20, s21, s22};
      obs_wv   = s_wv;
      obs_fd   = s_fd;
    end
  end

  // Reference model: the frame is kept as an image indexed by (row, col);
  // each window is cut straight out of that image.
  logic [7:0]  img [0:15][0:31];
  int          mw = 4, mh = 4, mr = 0, mc = 0;
  logic [71:0] exp_taps;
  logic        exp_wv, exp_fd;
  int          n_vec = 0, n_err = 0;
  int          nwin, ndone;

  function automatic logic [7:0] pixval(input int mode, input int r, input int c);
    if (mode == 0) return 8'(r * 16 + c);
    return 8'(8'hF0 + r * 4 + c);
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    rst       = 1'b0;
    @(posedge clk);
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      exp_fd = (mr == mh - 1) && (mc == mw - 1);
      if (mr >= 2 && mc >= 2) begin
        exp_wv   = 1'b1;
        exp_taps = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                    img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                    img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
      end
      mc = mc + 1;
      if (mc == mw) begin
        mc = 0;
        mr = (mr == mh - 1) ? 0 : mr + 1;
      end
    end
    #1;
    if (obs_wv) nwin++;
    if (obs_fd) ndone++;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    mr = 0;
    mc = 0;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      use_large = (k == 1);
      #0;
      n_vec++;
      if ({obs_wv, obs_fd, obs_taps} !== 74'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got wv=%0b fd=%0b taps=%h, want all zero",
                 k, obs_wv, obs_fd, obs_taps);
      end
    end
    use_large = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [71:0] first_win;
    logic        seen_first;
    nwin = 0; ndone = 0; seen_first = 1'b0; first_win = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, (r == 0 && c == 0), pixval(0, r, c));
        n_vec++;
        if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
          n_err++;
          $display("FAIL basic(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                   r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
        end
        if (obs_wv && !seen_first) begin
          first_win  = obs_taps;
          seen_first = 1'b1;
        end
      end
    end
    n_vec++;
    if (first_win !== 72'h00_01_02_10_11_12_20_21_22) begin
      n_err++;
      $display("FAIL basic_first_window: got %h, want 000102101112202122", first_win);
    end
    n_vec++;
    if (obs_taps !== 72'h11_12_13_21_22_23_31_32_33) begin
      n_err++;
      $display("FAIL basic_last_window: got %h, want 111213212223313233", obs_taps);
    end
    n_vec++;
    if (nwin != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL basic_counts: got windows=%0d done=%0d, want 4 and 1", nwin, ndone);
    end
  endtask

  task automatic test_gaps();
    nwin = 0; ndone = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        while ($urandom_range(0, 1) == 0) begin
          step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
          n_vec++;
          if ({obs_wv, obs_fd} !== 2'b00) begin
            n_err++;
            $display("FAIL gaps_idle: got wv=%0b fd=%0b, want 0 0", obs_wv, obs_fd);
          end
        end
        step(1'b1, (r == 0 && c == 0), pixval(0, r, c));
        n_vec++;
        if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
          n_err++;
          $display("FAIL gaps(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                   r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
        end
      end
    end
    n_vec++;
    if (nwin != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL gaps_counts: got windows=%0d done=%0d, want 4 and 1", nwin, ndone);
    end
  endtask

  task automatic test_back_to_back();
    int win2;
    nwin = 0; ndone = 0; win2 = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          step(1'b1, (r == 0 && c == 0), pixval(f, r, c));
          if (f == 1 && obs_wv) win2++;
          n_vec++;
          if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
            n_err++;
            $display("FAIL b2b f%0d(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                     f, r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
          end
        end
      end
    end
    n_vec++;
    if (win2 != 4 || nwin != 8 || ndone != 2) begin
      n_err++;
      $display("FAIL b2b_counts: got win2=%0d windows=%0d done=%0d, want 4 8 2", win2, nwin, ndone);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step(1'b1, (i == 0), pixval(0, i / 4, i % 4));
    do_reset(1);
    n_vec++;
    if ({obs_wv, obs_fd, obs_taps} !== 74'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got wv=%0b fd=%0b taps=%h, want all zero",
               obs_wv, obs_fd, obs_taps);
    end
    nwin = 0; ndone = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, 1'b0, pixval(1, r, c));
        n_vec++;
        if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
          n_err++;
          $display("FAIL reset_mid(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                   r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
        end
      end
    end
    n_vec++;
    if (nwin != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL reset_mid_counts: got windows=%0d done=%0d, want 4 and 1", nwin, ndone);
    end
  endtask

  task automatic test_sof_mid();
    for (int i = 0; i < 6; i++) step(1'b1, (i == 0), pixval(1, i / 4, i % 4));
    nwin = 0; ndone = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, (r == 0 && c == 0), pixval(0, r, c));
        n_vec++;
        if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
          n_err++;
          $display("FAIL sof_mid(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                   r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
        end
      end
    end
    n_vec++;
    if (nwin != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL sof_mid_counts: got windows=%0d done=%0d, want 4 and 1", nwin, ndone);
    end
  endtask

  task automatic test_large_random();
    use_large = 1'b1;
    mw = 24; mh = 13;
    do_reset(1);
    nwin = 0; ndone = 0;
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 24; c++) begin
        while ($urandom_range(0, 3) == 0) begin
          step(1'b0, 1'b0, 8'($urandom));
          n_vec++;
          if ({obs_wv, obs_fd} !== 2'b00) begin
            n_err++;
            $display("FAIL large_idle: got wv=%0b fd=%0b, want 0 0", obs_wv, obs_fd);
          end
        end
        step(1'b1, (r == 0 && c == 0), 8'($urandom));
        n_vec++;
        if ({obs_wv, obs_fd} !== {exp_wv, exp_fd} || (exp_wv && obs_taps !== exp_taps)) begin
          n_err++;
          $display("FAIL large(%0d,%0d): got wv=%0b fd=%0b taps=%h, want wv=%0b fd=%0b taps=%h",
                   r, c, obs_wv, obs_fd, obs_taps, exp_wv, exp_fd, exp_taps);
        end
      end
    end
    n_vec++;
    if (nwin != 22 * 11 || ndone != 1) begin
      n_err++;
      $display("FAIL large_counts: got windows=%0d done=%0d, want %0d and 1", nwin, ndone, 22 * 11);
    end
    use_large = 1'b0;
    mw = 4; mh = 4;
  endtask

  initial begin
    exp_taps = '0;
    exp_wv   = 1'b0;
    exp_fd   = 1'b0;
    nwin     = 0;
    ndone    = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_sof_mid();
    test_large_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window3x3_linebuf.md
Name: window3x3_linebuf

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel stage.
- Accepts one 8-bit blurred pixel per valid cycle in raster order.
- Keeps two line buffers plus a 3x3 shift window.
- Emits the nine window taps p00..p22 with a one-cycle valid strobe whenever a complete, non-border neighbourhood is available.

Parameters:
- IMG_W, 640, pixels per line (minimum 3).
- IMG_H, 480, lines per frame (minimum 3).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  DATA_W  input pixel.
- pix_valid  in  1  pix_in is accepted this cycle.
- sof  in  1  start of frame; qualified by pix_valid, marks pix_in as pixel (0,0).
- p00,p01,p02,p10,p11,p12,p20,p21,p22  out  DATA_W each  window taps; row index first, row 0 is oldest line.
- win_valid  out  1  taps hold a valid window this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at a clk edge): col=0, row=0, all p** =0, win_valid=0, frame_done=0. Line-buffer RAM contents are not reset; stale data is never exposed because win_valid is gated by row/col.
- Reset mid-frame aborts the frame. The next accepted pixel is (0,0) whether or not sof is asserted.
- Accepted pixel (pix_valid=1) at position (r,c):
  - Line buffer 1 is read at c, giving pixel (r-1,c). Line buffer 2 is read at c, giving pixel (r-2,c).
  - Line buffer 2[c] is written with the old line buffer 1[c]. Line buffer 1[c] is written with pix_in.
  - Read-before-write at the same address is required.
- Window shift on each accepted pixel: every row shifts left. New right column: p02=(r-2,c), p12=(r-1,c), p22=(r,c). Result is p00=(r-2,c-2) … p22=(r,c).
- Latency is 1 cycle. Taps and win_valid update on the edge that accepts the pixel and are visible the following cycle.
- win_valid=1 for exactly one cycle per accepted pixel with r>=2 and c>=2; otherwise 0. Per frame there are exactly (IMG_W-2)*(IMG_H-2) valid windows.
- Window centre p11 corresponds to image pixel (r-1,c-1). One-pixel border windows are not produced.
- pix_valid=0: counters, taps and line buffers hold; win_valid=0, frame_done=0. Gaps of any length are allowed and do not change window contents.
- Counters: after each accepted pixel, col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), row and col both wrap to 0 and frame_done pulses the next cycle, coincident with the final win_valid.
- sof=1 with pix_valid=1: the pixel is forced to (0,0) regardless of counter state; the next pixel is (0,1). A mid-frame sof resynchronises and no window is produced until r>=2, c>=2 of the new frame. sof with pix_valid=0 is ignored.
- Line wrap: the left two columns of each new line refill the shift window before c>=2, so no taps from the previous line reach a valid window.
- Back-to-back frames need no idle cycles. Line-buffer data from the previous frame is masked by the row>=2 gate.
- Widths: counters sized clog2(IMG_W) and clog2(IMG_H). No arithmetic on pixel data.

Test Plan:
- IMG_W=IMG_H=4, pixels value=r*16+c, continuous pix_valid, sof on first pixel -> 4 win_valid pulses. First window (1 cycle after pixel (2,2)) is p00=0x00 p01=0x01 p02=0x02 p10=0x10 p11=0x11 p12=0x12 p20=0x20 p21=0x21 p22=0x22. Last window is p00=0x11 … p22=0x33. frame_done pulses with the last window.
- Same image with pix_valid toggled randomly (~50% duty) -> identical window sequence and values. win_valid never asserted in a cycle not following an accepted pixel.
- Two frames back-to-back, second frame pixels = 0xF0+r*4+c -> second frame yields exactly 4 windows containing only second-frame values. frame_done pulses twice.
- rst asserted for one cycle after pixel (2,1) of frame 1, then a full frame sent without sof -> outputs 0 and win_valid=0 during reset. Frame is processed from (0,0) with correct 4 windows.
- sof pulsed mid-frame at pixel (1,2), then a full 4x4 frame -> no window from the aborted frame after sof. Exactly 4 correct windows follow.
- IMG_W=640, IMG_H=480 random image compared against a software 3x3 reference -> 638*478 windows, all taps match, one frame_done.
